wptr_full: RTL and testbench
============================

Name: wptr_full

Overview:
- Write-domain pointer and full-flag stage of the asynchronous FIFO.
- Sits directly upstream of asyn_cmp and drives its wptr input with a registered Gray pointer.
- Consumes asyn_cmp's afull_n and turns it into a write-clock-safe wfull flag.
- Generates the write enable and binary address for the dual-port RAM; flags overflow attempts.

Parameters:
- ADDR_WD, 4, pointer/address width; FIFO depth = 2^ADDR_WD; must be >= 2 (asyn_cmp quadrant logic uses the two MSBs).

Ports:
- wclk  input  1  write clock; all state updates on rising edge.
- wrst  input  1  synchronous, active-high reset.
- winc  input  1  write request from producer; level per cycle.
- afull_n  input  1  from asyn_cmp; asynchronous, active-low "going full" indication.
- wovf_clr  input  1  clears the sticky overflow flag.
- wen  output  1  RAM write enable; combinational = winc & ~wfull.
- waddr  output  ADDR_WD  RAM write address; binary pointer, registered.
- wptr  output  ADDR_WD  Gray write pointer to asyn_cmp and the read side; registered.
- wfull  output  1  FIFO full; producer must not count writes while high.
- wovf  output  1  sticky: winc seen while wfull.

Behaviour:
- Reset is synchronous and active-high on wclk. Reset values: wbin=0, wptr=0, waddr=0, wovf=0.
- wfull/wfull2 reset to 0 only if afull_n is high; the afull_n preset dominates reset.
- Pointer:
  - wbin is an ADDR_WD-bit binary counter.
  - On wen: wbin <= wbin+1, wrapping 2^ADDR_WD-1 -> 0; wptr <= (wbin+1) ^ ((wbin+1)>>1).
  - wptr must be a direct flop output so that exactly one bit toggles per increment, with no combinational glitches into asyn_cmp.
  - waddr = wbin (flop output).
  - No increment when wen=0.
- Write latency:
  - RAM write happens in the same cycle as wen.
  - wptr/waddr reflect the new value on the next edge.
- Full flag: two flops, wfull (output) and wfull2.
  - Asynchronous preset: afull_n low forces wfull=wfull2=1 immediately, independent of wclk. This is not a reset.
  - Otherwise, on each wclk edge: {wfull, wfull2} <= {wfull2, ~afull_n}.
  - Assertion is therefore immediate, so the final write that fills the FIFO blocks the next cycle.
  - Deassertion (a read frees space) takes 2 wclk edges after afull_n rises. This synchronises the release.
- Overflow:
  - wovf <= 1 on any edge where winc & wfull.
  - wovf <= 0 on wovf_clr.
  - Set wins when set and clear occur in the same cycle.
  - wovf has no other effect; the dropped write does not move the pointer.
- Boundaries:
  - Write on the cycle wfull goes high is blocked (wen=0).
  - Wrap at max address is seamless.
  - wrst asserted mid-stream returns pointers to 0 next edge, regardless of winc.
  - The system-level requirement that the read side is reset together with wrst is out of this block's scope.
  - winc held high while full: no pointer motion, wovf set.

Decomposition:
- Shared package fifo_pkg holds:
  - ADDR_WD default.
  - bin2gray and gray2bin functions, also used by the read-side rptr_empty.
- One natural sub-module: gray_cnt (binary + registered Gray counter with inc enable, synchronous active-high reset). It is reused by rptr_empty.
- The full-flag flops stay inline.

Test Plan:
- Reset: assert wrst 2 cycles with afull_n=1 -> wptr=0, waddr=0, wfull=0, wovf=0.
- Gray sequence: winc=1 for 16 cycles, afull_n=1, ADDR_WD=4 -> waddr 0..15 then 0.
  - wptr 0,1,3,2,6,7,5,4,C,D,F,E,A,B,9,8,0.
  - Exactly one bit changes per step.
- Full assertion: drive afull_n low mid-cycle -> wfull=1 before the next edge.
  - wen=0 on that cycle; waddr frozen.
- Full release: afull_n high at edge N -> wfull still 1 after edge N+1, 0 after edge N+2; writes resume at N+2.
- Overflow: winc=1 while wfull=1 for 3 cycles -> wovf=1, pointer unchanged.
  - wovf_clr with winc=0 -> wovf=0 next edge.
  - wovf_clr and winc&wfull in the same cycle -> wovf stays 1.
- Reset vs preset: wrst=1 with afull_n=0 -> pointers 0, wfull remains 1 until afull_n rises plus 2 edges.

Source files
------------

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared async-FIFO constants and Gray/binary conversion helpers
package fifo_pkg;

  localparam int ADDR_WD_DEFAULT = 4;

  // Gray conversions work on a 32-bit container. Callers zero-extend their
  // value on the way in and truncate the result on the way out.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_cnt.sv
// rtl/gray_cnt.sv - binary counter with registered Gray copy, shared by both FIFO pointer stages
module gray_cnt
  import fifo_pkg::*;
#(
  parameter int WD = ADDR_WD_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  output logic [WD-1:0] bin,
  output logic [WD-1:0] gray
);

  logic [WD-1:0] bin_next;

  assign bin_next = bin + WD'(1);

  // Gray is registered from bin_next so that exactly one flop output toggles per step.
  always_ff @(posedge clk) begin
    if (rst) begin
      bin  <= '0;
      gray <= '0;
    end else if (inc) begin
      bin  <= bin_next;
      gray <= WD'(bin2gray(32'(bin_next)));
    end
  end

endmodule

// File: rtl/wptr_full.sv
// rtl/wptr_full.sv - async FIFO write pointer, write enable and full/overflow flags
module wptr_full
  import fifo_pkg::*;
#(
  parameter int ADDR_WD = ADDR_WD_DEFAULT
) (
  input  logic               wclk,
  input  logic               wrst,
  input  logic               winc,
  input  logic               afull_n,
  input  logic               wovf_clr,
  output logic               wen,
  output logic [ADDR_WD-1:0] waddr,
  output logic [ADDR_WD-1:0] wptr,
  output logic               wfull,
  output logic               wovf
);

  logic wfull2;

  assign wen = winc & ~wfull;

  gray_cnt #(.WD(ADDR_WD)) u_gray_cnt (
    .clk  (wclk),
    .rst  (wrst),
    .inc  (wen),
    .bin  (waddr),
    .gray (wptr)
  );

  // afull_n preset sets full at once. Release passes through two wclk flops.
  // afull_n is known high in the clocked branches, so a constant 0 is shifted in.
  always_ff @(posedge wclk or negedge afull_n) begin
    if (!afull_n) begin
      wfull  <= 1'b1;
      wfull2 <= 1'b1;
    end else if (wrst) begin
      wfull  <= 1'b0;
      wfull2 <= 1'b0;
    end else begin
      wfull  <= wfull2;
      wfull2 <= 1'b0;
    end
  end

  always_ff @(posedge wclk) begin
    if (wrst) begin
      wovf <= 1'b0;
    end else if (winc && wfull) begin
      wovf <= 1'b1;
    end else if (wovf_clr) begin
      wovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wptr_full.sv
// tb/tb_wptr_full.sv - randomized self-checking bench for wptr_full with a behavioural model
module tb_wptr_full;

  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          wclk = 1'b0;
  logic          wrst, winc, afull_n, wovf_clr;
  logic          wen, wfull, wovf;
  logic [AW-1:0] waddr, wptr;

  int total = 0;
  int bad   = 0;

  // Model state: number of accepted writes mod depth, full flag, edges since release, overflow.
  int m_cnt = 0;
  bit m_full = 1'b0;
  int m_rel = 2;
  bit m_ovf = 1'b0;

  wptr_full #(.ADDR_WD(AW)) dut (
    .wclk     (wclk),
    .wrst     (wrst),
    .winc     (winc),
    .afull_n  (afull_n),
    .wovf_clr (wovf_clr),
    .wen      (wen),
    .waddr    (waddr),
    .wptr     (wptr),
    .wfull    (wfull),
    .wovf     (wovf)
  );

  always #5 wclk = ~wclk;

  function automatic logic [AW-1:0] gray_of(input int n);
    int b;
    b = n % DEPTH;
    return AW'(b ^ (b >> 1));
  endfunction

  task automatic set_in(input bit inc, input bit af, input bit clr, input bit rst);
    winc = inc; afull_n = af; wovf_clr = clr; wrst = rst;
    if (!af) begin
      m_full = 1'b1;
      m_rel  = 0;
    end
    #1;
  endtask

  task automatic clk_edge();
    bit e_wen;
    e_wen = winc && !m_full;
    @(posedge wclk);
    #1;
    if (wrst) begin
      m_cnt = 0;
      m_ovf = 1'b0;
    end else begin
      if (e_wen) m_cnt = (m_cnt + 1) % DEPTH;
      if (winc && m_full) m_ovf = 1'b1;
      else if (wovf_clr) m_ovf = 1'b0;
    end
    if (!afull_n) begin
      m_full = 1'b1;
      m_rel  = 0;
    end else if (wrst) begin
      m_full = 1'b0;
      m_rel  = 2;
    end else if (m_full) begin
      m_rel++;
      if (m_rel >= 2) m_full = 1'b0;
    end
  endtask

  task automatic test_reset();
    set_in(0, 1, 0, 1);
    clk_edge();
    clk_edge();
    total++; if (wptr !== 4'h0)  begin bad++; $display("FAIL reset_wptr got %h want 0", wptr); end
    total++; if (waddr !== 4'h0) begin bad++; $display("FAIL reset_waddr got %h want 0", waddr); end
    total++; if (wfull !== 1'b0) begin bad++; $display("FAIL reset_wfull got %b want 0", wfull); end
    total++; if (wovf !== 1'b0)  begin bad++; $display("FAIL reset_wovf got %b want 0", wovf); end
    set_in(0, 1, 0, 0);
  endtask

  task automatic test_gray_sequence();
    logic [AW-1:0] exp_g [17] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                   4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};
    logic [AW-1:0] prev;
    total++; if (wptr !== exp_g[0]) begin bad++; $display("FAIL gray_start got %h want %h", wptr, exp_g[0]); end
    for (int i = 0; i < 16; i++) begin
      prev = wptr;
      set_in(1, 1, 0, 0);
      total++; if (wen !== 1'b1) begin bad++; $display("FAIL gray_wen step %0d got %b want 1", i, wen); end
      clk_edge();
      total++;
      if (waddr !== AW'((i + 1) % DEPTH)) begin
        bad++; $display("FAIL gray_waddr step %0d got %h want %h", i, waddr, AW'((i + 1) % DEPTH));
      end
      total++;
      if (wptr !== exp_g[i+1]) begin
        bad++; $display("FAIL gray_wptr step %0d got %h want %h", i, wptr, exp_g[i+1]);
      end
      total++;
      if ($countones(wptr ^ prev) != 1) begin
        bad++; $display("FAIL gray_onebit step %0d got %0d toggles want 1", i, $countones(wptr ^ prev));
      end
    end
  endtask

  task automatic test_full_assert();
    logic [AW-1:0] held;
    set_in(1, 1, 0, 0);
    clk_edge();
    held = waddr;
    set_in(1, 0, 0, 0);
    total++; if (wfull !== 1'b1) begin bad++; $display("FAIL full_immediate got %b want 1", wfull); end
    total++; if (wen !== 1'b0)   begin bad++; $display("FAIL full_wen got %b want 0", wen); end
    clk_edge();
    total++; if (waddr !== held) begin bad++; $display("FAIL full_waddr_frozen got %h want %h", waddr, held); end
    total++; if (wovf !== m_ovf) begin bad++; $display("FAIL full_wovf got %b want %b", wovf, m_ovf); end
  endtask

  task automatic test_full_release();
    logic [AW-1:0] held;
    held = waddr;
    set_in(0, 1, 1, 0);
    clk_edge();
    total++; if (wfull !== 1'b1) begin bad++; $display("FAIL release_edge1 got %b want 1", wfull); end
    set_in(0, 1, 0, 0);
    clk_edge();
    total++; if (wfull !== 1'b0) begin bad++; $display("FAIL release_edge2 got %b want 0", wfull); end
    set_in(1, 1, 0, 0);
    total++; if (wen !== 1'b1) begin bad++; $display("FAIL release_wen got %b want 1", wen); end
    clk_edge();
    total++;
    if (waddr !== AW'(held + 1)) begin
      bad++; $display("FAIL release_waddr got %h want %h", waddr, AW'(held + 1));
    end
  endtask

  task automatic test_overflow();
    logic [AW-1:0] held_a, held_p;
    set_in(0, 0, 1, 0);
    clk_edge();
    held_a = waddr;
    held_p = wptr;
    for (int i = 0; i < 3; i++) begin
      set_in(1, 0, 0, 0);
      clk_edge();
    end
    total++; if (wovf !== 1'b1)    begin bad++; $display("FAIL ovf_set got %b want 1", wovf); end
    total++; if (waddr !== held_a) begin bad++; $display("FAIL ovf_waddr got %h want %h", waddr, held_a); end
    total++; if (wptr !== held_p)  begin bad++; $display("FAIL ovf_wptr got %h want %h", wptr, held_p); end
    set_in(0, 0, 1, 0);
    clk_edge();
    total++; if (wovf !== 1'b0) begin bad++; $display("FAIL ovf_clear got %b want 0", wovf); end
    set_in(1, 0, 1, 0);
    clk_edge();
    total++; if (wovf !== 1'b1) begin bad++; $display("FAIL ovf_set_wins got %b want 1", wovf); end
  endtask

  task automatic test_reset_vs_preset();
    set_in(1, 1, 1, 0);
    for (int i = 0; i < 5; i++) clk_edge();
    total++; if (waddr !== AW'(m_cnt)) begin bad++; $display("FAIL pre_rst_waddr got %h want %h", waddr, AW'(m_cnt)); end
    set_in(1, 0, 0, 1);
    clk_edge();
    total++; if (waddr !== 4'h0) begin bad++; $display("FAIL rstpre_waddr got %h want 0", waddr); end
    total++; if (wptr !== 4'h0)  begin bad++; $display("FAIL rstpre_wptr got %h want 0", wptr); end
    total++; if (wfull !== 1'b1) begin bad++; $display("FAIL rstpre_wfull got %b want 1", wfull); end
    set_in(0, 1, 0, 0);
    clk_edge();
    total++; if (wfull !== 1'b1) begin bad++; $display("FAIL rstpre_edge1 got %b want 1", wfull); end
    clk_edge();
    total++; if (wfull !== 1'b0) begin bad++; $display("FAIL rstpre_edge2 got %b want 0", wfull); end
  endtask

  task automatic test_random();
    bit inc, af, clr, rst;
    for (int i = 0; i < 400; i++) begin
      inc = ($urandom_range(0, 3) != 0);
      af  = ($urandom_range(0, 7) != 0);
      clr = ($urandom_range(0, 5) == 0);
      rst = ($urandom_range(0, 60) == 0);
      set_in(inc, af, clr, rst);
      total++;
      if (wen !== (inc && !m_full)) begin
        bad++; $display("FAIL rand_wen cyc %0d got %b want %b", i, wen, inc && !m_full);
      end
      clk_edge();
      total++;
      if (waddr !== AW'(m_cnt) || wptr !== gray_of(m_cnt)) begin
        bad++; $display("FAIL rand_ptr cyc %0d got addr %h ptr %h want addr %h ptr %h",
                        i, waddr, wptr, AW'(m_cnt), gray_of(m_cnt));
      end
      total++;
      if (wfull !== m_full || wovf !== m_ovf) begin
        bad++; $display("FAIL rand_flags cyc %0d got full %b ovf %b want full %b ovf %b",
                        i, wfull, wovf, m_full, m_ovf);
      end
    end
  endtask

  initial begin
    test_reset();
    test_gray_sequence();
    test_full_assert();
    test_full_release();
    test_overflow();
    test_reset_vs_preset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
